// File: rtl/lsu_rmw.sv
// lsu_rmw: byte/half/word load-store unit with read-modify-write for sub-word stores on a word-only memory.
// Optional LSU_PERF_EN adds saturating load/store/error response counters.
module lsu_rmw #(
    parameter int ADDR_W   = 32,
    parameter int DM_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_memr,
    output logic              dm_memwr,
    input  logic [31:0]       dm_rdata
`ifdef LSU_PERF_EN
    ,
    output logic [15:0]       cnt_load,
    output logic [15:0]       cnt_store,
    output logic [15:0]       cnt_err
`endif
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WB     = 2'd2;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merged;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    logic              w_acc;
    logic              w_word_st;
    logic              w_err;
    logic [4:0]        w_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_mask;
    logic [31:0]       w_merged;

    assign w_acc     = (r_state == S_ACCESS);
    assign w_word_st = r_we & (r_size == 2'b10);
    assign w_err     = (r_size == 2'b11)
                     | ((r_size == 2'b01) & r_addr[0])
                     | ((r_size == 2'b10) & (r_addr[1:0] != 2'b00))
                     | ({2'b00, r_addr[ADDR_W-1:2]} >= ADDR_W'(DM_WORDS));
    assign w_sh      = {r_addr[1:0], 3'b000};
    assign w_byte    = 8'(dm_rdata >> w_sh);
    assign w_half    = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign w_load    = (r_size == 2'b00) ? {{24{~r_unsigned & w_byte[7]}}, w_byte}
                     : (r_size == 2'b01) ? {{16{~r_unsigned & w_half[15]}}, w_half}
                     : dm_rdata;
    // Halves are 2-byte aligned here, so the same lane shift serves both sizes
    assign w_mask    = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merged  = (dm_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign dm_addr    = {r_addr[ADDR_W-1:2], 2'b00};
    assign dm_wdata   = (r_state == S_WB) ? r_merged : r_wdata;
    // Strobes are gated by rst so a reset edge never commits a pending write
    assign dm_memr    = ~rst & w_acc & ~w_err & ~w_word_st;
    assign dm_memwr   = ~rst & ((w_acc & ~w_err & w_word_st) | (r_state == S_WB));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (req_valid) begin
                    r_we       <= req_we;
                    r_size     <= req_size;
                    r_unsigned <= req_unsigned;
                    r_addr     <= req_addr;
                    r_wdata    <= req_wdata;
                    r_state    <= S_ACCESS;
                end
            end else if (w_acc) begin
                if (w_err || !r_we || w_word_st) begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= w_err;
                    r_resp_rdata <= (!w_err && !r_we) ? w_load : 32'h0;
                end else begin
                    r_merged <= w_merged;
                    r_state  <= S_WB;
                end
            end else if (r_state == S_WB) begin
                r_state      <= S_IDLE;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= 32'h0;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

`ifdef LSU_PERF_EN
    logic [15:0] r_cnt_load;
    logic [15:0] r_cnt_store;
    logic [15:0] r_cnt_err;

    assign cnt_load  = r_cnt_load;
    assign cnt_store = r_cnt_store;
    assign cnt_err   = r_cnt_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_load  <= '0;
            r_cnt_store <= '0;
            r_cnt_err   <= '0;
        end else if (r_resp_valid) begin
            if (r_resp_err)
                r_cnt_err <= r_cnt_err + {15'd0, r_cnt_err != 16'hFFFF};
            else if (r_we)
                r_cnt_store <= r_cnt_store + {15'd0, r_cnt_store != 16'hFFFF};
            else
                r_cnt_load <= r_cnt_load + {15'd0, r_cnt_load != 16'hFFFF};
        end
    end
`endif
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed vector bench for lsu_rmw with a word-only memory model.
module tb_lsu_rmw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_memr;
    logic        dm_memwr;
    logic [31:0] dm_rdata;
`ifdef LSU_PERF_EN
    logic [15:0] cnt_load, cnt_store, cnt_err;
`endif

    logic [31:0] mem [512];
    int total = 0;
    int bad = 0;
    int e_ld = 0, e_st = 0, e_er = 0;

    lsu_rmw dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_memr(dm_memr), .dm_memwr(dm_memwr),
        .dm_rdata(dm_rdata)
`ifdef LSU_PERF_EN
        , .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
`endif
    );

    always #5 clk = ~clk;

    assign dm_rdata = dm_memr ? mem[dm_addr[10:2]] : 32'h0;
    always @(posedge clk) if (dm_memwr) mem[dm_addr[10:2]] <= dm_wdata;

    always @(negedge clk)
        if (dm_memr && dm_memwr) begin
            bad++;
            $display("FAIL strobe_excl: memr=%b memwr=%b required not both 1", dm_memr, dm_memwr);
        end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nr;
        int          nw;
    } vec_t;

    vec_t v [32];
    int   nv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd,
                       input int lat, input int nr, input int nw);
        v[nv] = '{we, sz, uns, a, wd, err, rd, lat, nr, nw};
        nv++;
    endtask

    task automatic drive(input vec_t t);
        req_we       = t.we;
        req_size     = t.size;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
    endtask

    task automatic do_req(input string nm, input vec_t t);
        int n, nr, nw;
        drive(t);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = ~t.wdata;
        req_addr  = 32'h4;
        n = 0; nr = 0; nw = 0;
        while (!resp_valid && n < 8) begin
            nr += int'(dm_memr);
            nw += int'(dm_memwr);
            @(posedge clk);
            #1 n++;
        end
        chk({nm, " lat"}, n, t.lat);
        chk({nm, " err"}, {31'd0, resp_err}, {31'd0, t.err});
        chk({nm, " rdata"}, resp_rdata, t.rdata);
        chk({nm, " nmemr"}, nr, t.nr);
        chk({nm, " nmemwr"}, nw, t.nw);
        if (t.err) e_er++;
        else if (t.we) e_st++;
        else e_ld++;
    endtask

    initial begin
        vec_t t;
        // preload memory through the unit with word stores
        add(1, 2'b10, 0, 32'h20,  32'h11223344, 0, 0, 1, 0, 1);
        add(1, 2'b10, 0, 32'h30,  32'h80FF7F01, 0, 0, 1, 0, 1);
        add(1, 2'b10, 0, 32'h40,  32'h55555555, 0, 0, 1, 0, 1);
        add(1, 2'b10, 0, 32'h50,  32'hCAFEF00D, 0, 0, 1, 0, 1);
        add(1, 2'b10, 0, 32'h7FC, 32'h0BADC0DE, 0, 0, 1, 0, 1);
        add(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 0, 1, 0, 1);
        add(0, 2'b10, 0, 32'h10,  32'h0, 0, 32'hDEADBEEF, 1, 1, 0);
        add(1, 2'b00, 0, 32'h21,  32'h000000AA, 0, 0, 2, 1, 1);
        add(0, 2'b10, 0, 32'h20,  32'h0, 0, 32'h1122AA44, 1, 1, 0);
        add(0, 2'b00, 0, 32'h33,  32'h0, 0, 32'hFFFFFF80, 1, 1, 0);
        add(0, 2'b00, 1, 32'h33,  32'h0, 0, 32'h00000080, 1, 1, 0);
        add(0, 2'b01, 0, 32'h32,  32'h0, 0, 32'hFFFF80FF, 1, 1, 0);
        add(0, 2'b01, 1, 32'h30,  32'h0, 0, 32'h00007F01, 1, 1, 0);
        add(0, 2'b01, 0, 32'h41,  32'h0, 1, 0, 1, 0, 0);
        add(1, 2'b10, 0, 32'h42,  32'h99, 1, 0, 1, 0, 0);
        add(0, 2'b11, 0, 32'h40,  32'h0, 1, 0, 1, 0, 0);
        add(0, 2'b10, 0, 32'h800, 32'h0, 1, 0, 1, 0, 0);
        add(1, 2'b00, 0, 32'h801, 32'h12, 1, 0, 1, 0, 0);
        add(0, 2'b10, 0, 32'h40,  32'h0, 0, 32'h55555555, 1, 1, 0);
        add(0, 2'b10, 0, 32'h7FC, 32'h0, 0, 32'h0BADC0DE, 1, 1, 0);
        add(1, 2'b01, 0, 32'h12,  32'h1234BEEF, 0, 0, 2, 1, 1);
        add(0, 2'b10, 0, 32'h10,  32'h0, 0, 32'hBEEFBEEF, 1, 1, 0);
        add(0, 2'b00, 0, 32'h11,  32'h0, 0, 32'hFFFFFFBE, 1, 1, 0);
        add(0, 2'b00, 1, 32'h12,  32'h0, 0, 32'h000000EF, 1, 1, 0);
        add(0, 2'b01, 1, 32'h12,  32'h0, 0, 32'h0000BEEF, 1, 1, 0);
        add(0, 2'b00, 0, 32'h20,  32'h0, 0, 32'h00000044, 1, 1, 0);
        add(1, 2'b00, 0, 32'h23,  32'hFFFFFF01, 0, 0, 2, 1, 1);
        add(0, 2'b10, 0, 32'h20,  32'h0, 0, 32'h0122AA44, 1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst strobes", {30'd0, dm_memr, dm_memwr}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle resp_err", {31'd0, resp_err}, 32'd0);
        chk("idle resp_rdata", resp_rdata, 32'd0);
        chk("idle dm_addr", dm_addr, 32'd0);

        for (int i = 0; i < nv; i++) do_req($sformatf("v%0d", i), v[i]);

        // sub-word store aborted by reset during write-back
        t = '{1'b1, 2'b00, 1'b0, 32'h51, 32'h77, 1'b0, 32'h0, 0, 0, 0};
        drive(t);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("abort access memr", {31'd0, dm_memr}, 32'd1);
        @(posedge clk);
        #1 chk("abort wb memwr", {31'd0, dm_memwr}, 32'd1);
        rst = 1'b1;
        #1 chk("abort rst gates memwr", {31'd0, dm_memwr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        e_ld = 0; e_st = 0; e_er = 0;
        chk("abort ready", {31'd0, req_ready}, 32'd1);
        chk("abort no resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 chk("abort no late resp", {31'd0, resp_valid}, 32'd0);
        t = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, 32'hCAFEF00D, 1, 1, 0};
        do_req("abort reread", t);

        // back-to-back with req_valid held high; inputs change while busy
        t = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 0, 0, 0};
        drive(t);
        req_valid = 1'b1;
        @(posedge clk);
        #1 t.addr = 32'h30;
        drive(t);
        chk("b2b busy", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 chk("b2b resp1 valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b resp1 data", resp_rdata, 32'hBEEFBEEF);
        chk("b2b ready in resp", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b accepted", {31'd0, req_ready}, 32'd0);
        chk("b2b resp1 pulse", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 chk("b2b resp2 valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b resp2 data", resp_rdata, 32'h80FF7F01);
        e_ld += 2;

        t = '{1'b1, 2'b10, 1'b0, 32'h60, 32'h01020304, 1'b0, 32'h0, 1, 0, 1};
        do_req("perf sw", t);
        t = '{1'b1, 2'b00, 1'b0, 32'h62, 32'hAB, 1'b0, 32'h0, 2, 1, 1};
        do_req("perf sb", t);
        t = '{1'b0, 2'b01, 1'b0, 32'h63, 32'h0, 1'b1, 32'h0, 1, 0, 0};
        do_req("perf err", t);
        t = '{1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 1'b0, 32'h01AB0304, 1, 1, 0};
        do_req("perf reread", t);
        e_ld--;
`ifdef LSU_PERF_EN
        chk("cnt_load", {16'd0, cnt_load}, e_ld + 1);
        chk("cnt_store", {16'd0, cnt_store}, e_st);
        chk("cnt_err", {16'd0, cnt_err}, e_er);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
